// File: rtl/thor2023_icache_ctrl_pkg.sv
// Thor2023Pkg: shared address/ASID types, cache line layout and refill controller states
package Thor2023Pkg;
  localparam int ICacheLineWidth = 256;
  typedef logic [31:0] address_t;
  typedef logic [11:0] asid_t;
  typedef struct packed {
    address_t vtag;
    address_t ptag;
    logic [1:0] v;
    logic [ICacheLineWidth-1:0] data;
  } ICacheLine;
  typedef enum logic [2:0] {IDLE, XLAT, BUSRD, WRITE, SETTLE, INV} icctrl_state_t;
endpackage

// File: rtl/thor2023_icache_ctrl.sv
// thor2023_icache_ctrl: instruction cache miss refill and invalidate controller
module thor2023_icache_ctrl
  import Thor2023Pkg::*;
#(
  parameter int WAYS = 4,
  parameter int LOBIT = 6,
  parameter int BEATS = ICacheLineWidth / 128
) (
  input  logic                    rst,
  input  logic                    clk,
  input  logic                    ip_valid,
  input  logic                    ihit,
  input  address_t                miss_adr,
  input  asid_t                   miss_asid,
  output logic                    tlb_req,
  output address_t                tlb_vadr,
  output asid_t                   tlb_asid,
  input  logic                    tlb_ack,
  input  logic                    tlb_fault,
  input  address_t                tlb_padr,
  output logic                    cyc,
  output logic                    stb,
  output address_t                adr,
  output logic [15:0]             sel,
  input  logic                    ack,
  input  logic                    err,
  input  logic [127:0]            dat_i,
  input  logic                    inv_req,
  input  logic                    inv_all,
  input  address_t                inv_adr,
  output logic                    inv_ack,
  output ICacheLine               ic_line_o,
  output logic [$clog2(WAYS)-1:0] wway,
  output logic                    wr_ic,
  output logic                    invce,
  output logic                    invline,
  output logic                    invall,
  output logic                    busy,
  output logic                    fault,
  output address_t                fault_adr
);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int WW = $clog2(WAYS);
  localparam address_t LMASK = address_t'((1 << (LOBIT - 1)) - 1);
  icctrl_state_t state, state_n;
  address_t vadr, padr, inv_adr_r;
  asid_t asid_r;
  logic [BW-1:0] beat;
  logic [WW-1:0] way;
  logic scnt, fault_n, beat_ok;
  logic [ICacheLineWidth-1:0] line;
  assign beat_ok = (state == BUSRD) && ack && !err;
  assign fault_n = (state == XLAT && tlb_ack && tlb_fault) || (state == BUSRD && err);
  assign stb = cyc;
  assign sel = {16{cyc}};
  assign adr = cyc ? padr + address_t'({beat, 4'b0000}) : '0;
  assign busy = state != IDLE;
  assign wway = way;
  assign tlb_vadr = vadr;
  assign tlb_asid = asid_r;
  // next-state selection; err outranks ack, invalidate outranks a miss
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = inv_req ? INV : (ip_valid && !ihit) ? XLAT : IDLE;
      XLAT:    state_n = !tlb_ack ? XLAT : tlb_fault ? IDLE : BUSRD;
      BUSRD:   state_n = err ? IDLE : (ack && beat == BW'(BEATS - 1)) ? WRITE : BUSRD;
      WRITE:   state_n = SETTLE;
      SETTLE:  state_n = scnt ? IDLE : SETTLE;
      default: state_n = IDLE;
    endcase
  end
  // line presented to the cache: full refill on write, target tag on invalidate
  always_comb begin
    ic_line_o = (state == WRITE) ? ICacheLine'{vtag: vadr, ptag: padr, v: '1, data: line}
              : (state == INV) ? ICacheLine'{vtag: inv_adr_r, ptag: '0, v: '0, data: '0}
              : '0;
  end
  // state, registered pulses and refill bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tlb_req <= 1'b0;
      cyc <= 1'b0;
      wr_ic <= 1'b0;
      invce <= 1'b0;
      inv_ack <= 1'b0;
      invall <= 1'b0;
      invline <= 1'b0;
      fault <= 1'b0;
      fault_adr <= '0;
      vadr <= '0;
      asid_r <= '0;
      padr <= '0;
      inv_adr_r <= '0;
      beat <= '0;
      way <= '0;
      scnt <= 1'b0;
      line <= '0;
    end else begin
      state <= state_n;
      tlb_req <= state_n == XLAT;
      cyc <= state_n == BUSRD;
      wr_ic <= state_n == WRITE;
      invce <= state_n == INV;
      inv_ack <= state_n == INV;
      invall <= state_n == INV && inv_all;
      invline <= state_n == INV && !inv_all;
      fault <= fault_n;
      if (fault_n) fault_adr <= vadr;
      if (state == IDLE && state_n == XLAT) {vadr, asid_r} <= {miss_adr, miss_asid};
      if (state == XLAT && tlb_ack && !tlb_fault) padr <= tlb_padr & ~LMASK;
      if (state == IDLE && state_n == INV) inv_adr_r <= inv_adr;
      beat <= (state == BUSRD) ? beat + BW'(beat_ok) : '0;
      if (beat_ok) line[int'(beat)*128 +: 128] <= dat_i;
      if (wr_ic) way <= (way == WW'(WAYS - 1)) ? '0 : way + 1'b1;
      scnt <= (state == SETTLE) && !scnt;
    end
  end
endmodule

// File: tb/tb_thor2023_icache_ctrl.sv
// tb_thor2023_icache_ctrl: randomized directed bench with a line-level reference model
module tb_thor2023_icache_ctrl;
  import Thor2023Pkg::*;
  localparam int WAYS = 4;
  localparam int BEATS = ICacheLineWidth / 128;
  localparam int WW = $clog2(WAYS);
  logic clk = 1'b0, rst = 1'b1;
  logic ip_valid = 0, ihit = 0, tlb_ack = 0, tlb_fault = 0, ack = 0, err = 0;
  logic inv_req = 0, inv_all = 0;
  address_t miss_adr = '0, tlb_padr = '0, inv_adr = '0;
  asid_t miss_asid = '0;
  logic [127:0] dat_i = '0;
  logic tlb_req, cyc, stb, inv_ack, wr_ic, invce, invline, invall, busy, fault;
  address_t tlb_vadr, adr, fault_adr;
  asid_t tlb_asid;
  logic [15:0] sel;
  ICacheLine ic_line_o;
  logic [WW-1:0] wway;
  int n_chk = 0, n_fail = 0, exp_way = 0;
  always #5 clk = ~clk;
  thor2023_icache_ctrl #(.WAYS(WAYS), .LOBIT(6), .BEATS(BEATS)) dut (
    .rst(rst), .clk(clk), .ip_valid(ip_valid), .ihit(ihit), .miss_adr(miss_adr),
    .miss_asid(miss_asid), .tlb_req(tlb_req), .tlb_vadr(tlb_vadr), .tlb_asid(tlb_asid),
    .tlb_ack(tlb_ack), .tlb_fault(tlb_fault), .tlb_padr(tlb_padr), .cyc(cyc), .stb(stb),
    .adr(adr), .sel(sel), .ack(ack), .err(err), .dat_i(dat_i), .inv_req(inv_req),
    .inv_all(inv_all), .inv_adr(inv_adr), .inv_ack(inv_ack), .ic_line_o(ic_line_o),
    .wway(wway), .wr_ic(wr_ic), .invce(invce), .invline(invline), .invall(invall),
    .busy(busy), .fault(fault), .fault_adr(fault_adr)
  );
  // memory contents seen on the bus, derived from the beat address
  function automatic logic [127:0] mdat(address_t a);
    return {a, ~a, a ^ 32'hA5A5_5A5A, a + 32'h1357};
  endfunction
  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // one miss from request to return to IDLE, acting as fetch unit, TLB and bus slave
  task automatic refill(input address_t va, input address_t pa, input int tdly, input int err_beat,
                        input bit ackerr, input bit tfault, input bit rst_mid);
    logic [ICacheLineWidth-1:0] exp_line;
    asid_t asid;
    int n;
    bit found;
    asid = asid_t'($urandom);
    ip_valid = 1; ihit = 0; miss_adr = va; miss_asid = asid;
    found = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (tlb_req) begin found = 1; break; end
    end
    chk("tlb_req_seen", 256'(found), 256'(1));
    ip_valid = 0;
    chk("tlb_vadr", 256'(tlb_vadr), 256'(va));
    chk("tlb_asid", 256'(tlb_asid), 256'(asid));
    chk("xlat_busy", 256'(busy), 256'(1));
    for (int i = 0; i < tdly; i++) begin
      tick;
      chk("tlb_req_held", 256'({tlb_req, cyc}), 256'(2'b10));
    end
    tlb_ack = 1; tlb_fault = tfault; tlb_padr = pa;
    tick;
    tlb_ack = 0; tlb_fault = 0;
    chk("tlb_req_drop", 256'(tlb_req), 256'(0));
    if (tfault) begin
      chk("tf_fault", 256'({fault, cyc, busy}), 256'(3'b100));
      chk("tf_fault_adr", 256'(fault_adr), 256'(va));
      tick;
      chk("tf_after", 256'({fault, cyc, wr_ic, busy}), 256'(0));
      return;
    end
    for (int b = 0; b < BEATS; b++) begin
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        chk("wait_adr", 256'({cyc, adr}), 256'({1'b1, pa + address_t'(16 * b)}));
        tick;
      end
      chk("beat_bus", 256'({cyc, stb, sel}), 256'({2'b11, 16'hFFFF}));
      chk("beat_adr", 256'(adr), 256'(pa + address_t'(16 * b)));
      if (rst_mid) begin
        #3 rst = 1;
        #1 chk("rst_drop", 256'({cyc, stb, busy}), 256'(0));
        tick;
        tick;
        chk("rst_hold", 256'({wr_ic, cyc, tlb_req}), 256'(0));
        rst = 0;
        exp_way = 0;
        tick;
        chk("rst_after", 256'({busy, wr_ic, cyc, fault}), 256'(0));
        chk("rst_way", 256'(wway), 256'(0));
        return;
      end
      exp_line[b*128 +: 128] = mdat(pa + address_t'(16 * b));
      ack = (b != err_beat) || ackerr;
      err = b == err_beat;
      dat_i = mdat(pa + address_t'(16 * b));
      tick;
      ack = 0; err = 0;
      if (b == err_beat) begin
        chk("err_drop", 256'({cyc, stb, wr_ic, fault}), 256'(4'b0001));
        chk("err_fault_adr", 256'(fault_adr), 256'(va));
        chk("err_way", 256'(wway), 256'(exp_way));
        tick;
        chk("err_after", 256'({fault, wr_ic, busy, cyc}), 256'(0));
        return;
      end
    end
    chk("wr_pulse", 256'({cyc, wr_ic, fault, invce}), 256'(4'b0100));
    chk("wr_way", 256'(wway), 256'(exp_way));
    chk("wr_vtag", 256'(ic_line_o.vtag), 256'(va));
    chk("wr_ptag", 256'(ic_line_o.ptag), 256'(pa));
    chk("wr_v", 256'(ic_line_o.v), 256'(2'b11));
    chk("wr_data", 256'(ic_line_o.data), 256'(exp_line));
    exp_way = (exp_way + 1) % WAYS;
    tick;
    chk("wr_once", 256'({wr_ic, busy}), 256'(2'b01));
    chk("way_next", 256'(wway), 256'(exp_way));
    n = 0;
    while (busy && n < 6) begin
      tick;
      n++;
    end
    chk("settle_len", 256'(n), 256'(2));
  endtask
  task automatic inv(input address_t a, input bit all);
    inv_req = 1; inv_all = all; inv_adr = a;
    tick;
    chk("inv_pulse", 256'({invce, inv_ack, invall, invline}), 256'({2'b11, all, !all}));
    chk("inv_vtag", 256'(ic_line_o.vtag), 256'(a));
    chk("inv_excl", 256'({wr_ic, fault, cyc}), 256'(0));
    inv_req = 0;
    tick;
    chk("inv_after", 256'({invce, inv_ack, busy}), 256'(0));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    address_t va, pa;
    int r;
    repeat (3) tick;
    chk("rst_ctl", 256'({tlb_req, cyc, stb, wr_ic, invce, invline, invall, inv_ack, fault, busy}), 256'(0));
    chk("rst_bus", 256'({sel, adr, fault_adr}), 256'(0));
    chk("rst_line", 256'(ic_line_o), 256'(0));
    chk("rst_way", 256'(wway), 256'(0));
    rst = 0;
    tick;
    refill(32'h1240, 32'h81240, 3, -1, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      refill(32'h2000 + 32'(i) * 32'h40, 32'h9000 + 32'(i) * 32'h40, $urandom_range(0, 3), -1, 0, 0, 0);
    refill(32'h3320, 32'h55320, 1, 1, 0, 0, 0);
    refill(32'h3340, 32'h55340, 0, 0, 1, 0, 0);
    refill(32'h4460, 32'h66460, 2, -1, 0, 1, 0);
    refill(32'h5580, 32'h77580, 1, -1, 0, 0, 0);
    inv(32'h1240, 0);
    inv(32'h0, 1);
    inv_req = 1; inv_all = 0; inv_adr = 32'h6600;
    ip_valid = 1; ihit = 0; miss_adr = 32'h66A0;
    tick;
    chk("both_inv_first", 256'({invce, inv_ack, invline, tlb_req, busy}), 256'(5'b11101));
    chk("both_inv_vtag", 256'(ic_line_o.vtag), 256'(32'h6600));
    inv_req = 0;
    refill(32'h66A0, 32'h886A0, 1, -1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      va = $urandom & 32'hFFFF_FFE0;
      pa = $urandom & 32'hFFFF_FFE0;
      r = int'($urandom_range(0, 3));
      refill(va, pa, int'($urandom_range(0, 4)), r == 0 ? int'($urandom_range(0, BEATS - 1)) : -1,
             1'($urandom_range(0, 1)), r == 1, 0);
      if ($urandom_range(0, 1) == 1) inv($urandom & 32'hFFFF_FFE0, 1'($urandom_range(0, 1)));
    end
    refill(32'h7700, 32'h99700, 1, -1, 0, 0, 0);
    refill(32'h7720, 32'h99720, 2, -1, 0, 0, 1);
    refill(32'h7740, 32'h99740, 0, -1, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
